// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one ram_bus slave between the instruction-fetch and load/store ports.
// Round-robin tie-break; an optional AMO lock holds off fetches during an AMO read-modify-write.
module ram_arbiter #(
    parameter bit FETCH_FIRST     = 1'b1,
    parameter bit ENABLE_AMO_LOCK = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inst_stb_i,
    input  logic [31:0] inst_addr_i,
    output logic        inst_ack_o,
    output logic [31:0] inst_data_o,
    input  logic        data_stb_i,
    input  logic [3:0]  data_sel_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [2:0]  data_addr_tag_i,
    input  logic [31:0] data_data_i,
    output logic        data_ack_o,
    output logic [31:0] data_data_o,
    output logic        data_data_tag_o,
    output logic        ram_stb_o,
    output logic [3:0]  ram_sel_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [2:0]  ram_addr_tag_o,
    output logic [31:0] ram_data_o,
    input  logic        ram_ack_i,
    input  logic [31:0] ram_data_i,
    input  logic        ram_data_tag_i
);
    // Address tag = {mode[1:0], lock}; LR/SC mode (2'b01) never touches the bus lock.
    localparam logic [1:0] AddrTagModeNone = 2'b00;
    localparam logic [1:0] AddrTagModeAmo  = 2'b10;
    localparam logic       AddrTagUnlock   = 1'b0;
    localparam logic       AddrTagLock     = 1'b1;

    typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;  // 1: inst port, 0: data port
    logic        amo_lock_q, amo_lock_d;
    logic        ram_stb_q, ram_stb_d;
    logic [3:0]  ram_sel_q, ram_sel_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [2:0]  ram_addr_tag_q, ram_addr_tag_d;
    logic [31:0] ram_data_q, ram_data_d;
    logic        inst_ack_q, inst_ack_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic        data_ack_q, data_ack_d;
    logic [31:0] data_data_q, data_data_d;
    logic        data_data_tag_q, data_data_tag_d;

    logic inst_elig;
    logic pick_inst;

    assign inst_elig = inst_stb_i & ~amo_lock_q;
    assign pick_inst = inst_elig & (~data_stb_i | ~last_grant_q);

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        amo_lock_d      = amo_lock_q;
        ram_stb_d       = ram_stb_q;
        ram_sel_d       = ram_sel_q;
        ram_we_d        = ram_we_q;
        ram_addr_d      = ram_addr_q;
        ram_addr_tag_d  = ram_addr_tag_q;
        ram_data_d      = ram_data_q;
        inst_ack_d      = 1'b0;
        inst_data_d     = inst_data_q;
        data_ack_d      = 1'b0;
        data_data_d     = data_data_q;
        data_data_tag_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (inst_elig || data_stb_i) begin
                    state_d      = StGrant;
                    last_grant_d = pick_inst;
                    ram_stb_d    = 1'b1;
                    if (pick_inst) begin
                        ram_sel_d      = 4'hF;
                        ram_we_d       = 1'b0;
                        ram_addr_d     = inst_addr_i;
                        ram_addr_tag_d = {AddrTagModeNone, AddrTagUnlock};
                        ram_data_d     = 32'h0;
                    end else begin
                        ram_sel_d      = data_sel_i;
                        ram_we_d       = data_we_i;
                        ram_addr_d     = data_addr_i;
                        ram_addr_tag_d = data_addr_tag_i;
                        ram_data_d     = data_data_i;
                    end
                end
            end
            StGrant: begin
                if (ram_ack_i) begin
                    state_d   = StResp;
                    ram_stb_d = 1'b0;
                    if (last_grant_q) begin
                        inst_ack_d  = 1'b1;
                        inst_data_d = ram_data_i;
                    end else begin
                        data_ack_d      = 1'b1;
                        data_data_d     = ram_data_i;
                        data_data_tag_d = ram_data_tag_i;
                        if (ram_addr_tag_q == {AddrTagModeAmo, AddrTagLock} && !ram_we_q) begin
                            amo_lock_d = 1'b1;
                        end else if (ram_addr_tag_q == {AddrTagModeAmo, AddrTagUnlock} &&
                                     ram_we_q) begin
                            amo_lock_d = 1'b0;
                        end
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            last_grant_q    <= ~FETCH_FIRST;
            amo_lock_q      <= 1'b0;
            ram_stb_q       <= 1'b0;
            ram_sel_q       <= 4'h0;
            ram_we_q        <= 1'b0;
            ram_addr_q      <= 32'h0;
            ram_addr_tag_q  <= 3'h0;
            ram_data_q      <= 32'h0;
            inst_ack_q      <= 1'b0;
            inst_data_q     <= 32'h0;
            data_ack_q      <= 1'b0;
            data_data_q     <= 32'h0;
            data_data_tag_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            amo_lock_q      <= amo_lock_d & ENABLE_AMO_LOCK;
            ram_stb_q       <= ram_stb_d;
            ram_sel_q       <= ram_sel_d;
            ram_we_q        <= ram_we_d;
            ram_addr_q      <= ram_addr_d;
            ram_addr_tag_q  <= ram_addr_tag_d;
            ram_data_q      <= ram_data_d;
            inst_ack_q      <= inst_ack_d;
            inst_data_q     <= inst_data_d;
            data_ack_q      <= data_ack_d;
            data_data_q     <= data_data_d;
            data_data_tag_q <= data_data_tag_d;
        end
    end

    assign ram_stb_o       = ram_stb_q;
    assign ram_sel_o       = ram_sel_q;
    assign ram_we_o        = ram_we_q;
    assign ram_addr_o      = ram_addr_q;
    assign ram_addr_tag_o  = ram_addr_tag_q;
    assign ram_data_o      = ram_data_q;
    assign inst_ack_o      = inst_ack_q;
    assign inst_data_o     = inst_data_q;
    assign data_ack_o      = data_ack_q;
    assign data_data_o     = data_data_q;
    assign data_data_tag_o = data_data_tag_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed stimulus pushes expected grants/acks,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ram_arbiter;
    localparam logic [2:0] TagNone      = 3'b000;
    localparam logic [2:0] TagAmoLock   = 3'b101;
    localparam logic [2:0] TagAmoUnlock = 3'b100;
    localparam logic [2:0] TagLrLock    = 3'b011;
    localparam logic [2:0] TagScUnlock  = 3'b010;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  tag;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic        is_inst;
        logic [31:0] data;
        logic        tag;
    } resp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_stb_i, data_stb_i, data_we_i, ram_ack_i, ram_data_tag_i;
    logic [31:0] inst_addr_i, data_addr_i, data_data_i, ram_data_i;
    logic [3:0]  data_sel_i;
    logic [2:0]  data_addr_tag_i;
    logic        inst_ack_o, data_ack_o, data_data_tag_o, ram_stb_o, ram_we_o;
    logic [31:0] inst_data_o, data_data_o, ram_addr_o, ram_data_o;
    logic [3:0]  ram_sel_o;
    logic [2:0]  ram_addr_tag_o;
    logic        d1_inst_ack_o, d1_data_ack_o, d1_data_data_tag_o, d1_ram_stb_o, d1_ram_we_o;
    logic [31:0] d1_inst_data_o, d1_data_data_o, d1_ram_addr_o, d1_ram_data_o;
    logic [3:0]  d1_ram_sel_o;
    logic [2:0]  d1_ram_addr_tag_o;

    int     n_tests = 0;
    int     n_fail  = 0;
    grant_t exp_grant_q[$];
    resp_t  exp_resp_q[$];
    grant_t mon_g;
    resp_t  mon_r;
    logic   prev_stb = 1'b0;

    always #5 clk_i = ~clk_i;

    ram_arbiter #(.FETCH_FIRST(1'b1), .ENABLE_AMO_LOCK(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_stb_i(inst_stb_i), .inst_addr_i(inst_addr_i),
        .inst_ack_o(inst_ack_o), .inst_data_o(inst_data_o),
        .data_stb_i(data_stb_i), .data_sel_i(data_sel_i), .data_we_i(data_we_i),
        .data_addr_i(data_addr_i), .data_addr_tag_i(data_addr_tag_i),
        .data_data_i(data_data_i), .data_ack_o(data_ack_o), .data_data_o(data_data_o),
        .data_data_tag_o(data_data_tag_o),
        .ram_stb_o(ram_stb_o), .ram_sel_o(ram_sel_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_addr_tag_o(ram_addr_tag_o), .ram_data_o(ram_data_o),
        .ram_ack_i(ram_ack_i), .ram_data_i(ram_data_i), .ram_data_tag_i(ram_data_tag_i)
    );

    // Data-first variant, run in lockstep on the same inputs.
    ram_arbiter #(.FETCH_FIRST(1'b0), .ENABLE_AMO_LOCK(1'b1)) dut_d1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_stb_i(inst_stb_i), .inst_addr_i(inst_addr_i),
        .inst_ack_o(d1_inst_ack_o), .inst_data_o(d1_inst_data_o),
        .data_stb_i(data_stb_i), .data_sel_i(data_sel_i), .data_we_i(data_we_i),
        .data_addr_i(data_addr_i), .data_addr_tag_i(data_addr_tag_i),
        .data_data_i(data_data_i), .data_ack_o(d1_data_ack_o), .data_data_o(d1_data_data_o),
        .data_data_tag_o(d1_data_data_tag_o),
        .ram_stb_o(d1_ram_stb_o), .ram_sel_o(d1_ram_sel_o), .ram_we_o(d1_ram_we_o),
        .ram_addr_o(d1_ram_addr_o), .ram_addr_tag_o(d1_ram_addr_tag_o),
        .ram_data_o(d1_ram_data_o),
        .ram_ack_i(ram_ack_i), .ram_data_i(ram_data_i), .ram_data_tag_i(ram_data_tag_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (ram_stb_o && !prev_stb) begin
            if (exp_grant_q.size() == 0) begin
                check("unexpected_grant", {31'h0, ram_stb_o}, 32'h0);
            end else begin
                mon_g = exp_grant_q.pop_front();
                check("grant_addr", ram_addr_o, mon_g.addr);
                check("grant_sel", {28'h0, ram_sel_o}, {28'h0, mon_g.sel});
                check("grant_we", {31'h0, ram_we_o}, {31'h0, mon_g.we});
                check("grant_tag", {29'h0, ram_addr_tag_o}, {29'h0, mon_g.tag});
                check("grant_wdata", ram_data_o, mon_g.wdata);
            end
        end
        prev_stb <= ram_stb_o;
        if (inst_ack_o || data_ack_o) begin
            if (exp_resp_q.size() == 0) begin
                check("unexpected_ack", {30'h0, inst_ack_o, data_ack_o}, 32'h0);
            end else begin
                mon_r = exp_resp_q.pop_front();
                check("ack_inst_port", {31'h0, inst_ack_o}, {31'h0, mon_r.is_inst});
                check("ack_data_port", {31'h0, data_ack_o}, {31'h0, ~mon_r.is_inst});
                if (mon_r.is_inst) begin
                    check("inst_rdata", inst_data_o, mon_r.data);
                end else begin
                    check("data_rdata", data_data_o, mon_r.data);
                    check("data_rtag", {31'h0, data_data_tag_o}, {31'h0, mon_r.tag});
                end
            end
        end
    end

    task automatic exp_inst(input logic [31:0] addr, input logic [31:0] rdata);
        exp_grant_q.push_back('{addr, 4'hF, 1'b0, TagNone, 32'h0});
        exp_resp_q.push_back('{1'b1, rdata, 1'b0});
    endtask

    // Waits (bounded) for a strobe, then acks lat cycles after it was first seen.
    task automatic serve(input int lat, input logic [31:0] rdata, input logic rtag);
        int k = 0;
        while (!ram_stb_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        if (!ram_stb_o) begin
            check("grant_timeout", {31'h0, ram_stb_o}, 32'h1);
            return;
        end
        repeat (lat - 1) @(negedge clk_i);
        ram_ack_i = 1'b1;
        ram_data_i = rdata;
        ram_data_tag_i = rtag;
        @(negedge clk_i);
        ram_ack_i = 1'b0;
        ram_data_tag_i = 1'b0;
    endtask

    task automatic do_data(input logic [3:0] sel, input logic we, input logic [31:0] addr,
                           input logic [2:0] tag, input logic [31:0] wdata, input int lat,
                           input logic [31:0] rdata, input logic rtag);
        exp_grant_q.push_back('{addr, sel, we, tag, wdata});
        exp_resp_q.push_back('{1'b0, rdata, rtag});
        data_sel_i = sel;
        data_we_i = we;
        data_addr_i = addr;
        data_addr_tag_i = tag;
        data_data_i = wdata;
        data_stb_i = 1'b1;
        serve(lat, rdata, rtag);
        data_stb_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        inst_stb_i = 1'b0; inst_addr_i = 32'h0;
        data_stb_i = 1'b0; data_sel_i = 4'h0; data_we_i = 1'b0;
        data_addr_i = 32'h0; data_addr_tag_i = 3'h0; data_data_i = 32'h0;
        ram_ack_i = 1'b0; ram_data_i = 32'h0; ram_data_tag_i = 1'b0;
        #2 rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_ctrl", {27'h0, ram_stb_o, ram_we_o, inst_ack_o, data_ack_o, data_data_tag_o},
              32'h0);
        check("rst_sel_tag", {25'h0, ram_sel_o, ram_addr_tag_o}, 32'h0);
        check("rst_ram_addr", ram_addr_o, 32'h0);
        check("rst_ram_data", ram_data_o, 32'h0);
        check("rst_inst_data", inst_data_o, 32'h0);
        check("rst_data_data", data_data_o, 32'h0);

        // Round-robin: both requesters high out of reset.
        inst_addr_i = 32'h3000;
        data_sel_i = 4'hF; data_addr_i = 32'h4000; data_data_i = 32'h4444;
        inst_stb_i = 1'b1; data_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                exp_inst(32'h3000, 32'hA000_0000 + i);
            end else begin
                exp_grant_q.push_back('{32'h4000, 4'hF, 1'b0, TagNone, 32'h4444});
                exp_resp_q.push_back('{1'b0, 32'hA000_0000 + i, 1'b0});
            end
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serve(2, 32'hA000_0000 + i, 1'b0);
            check("rr_d1_addr", d1_ram_addr_o, (i % 2 == 0) ? 32'h4000 : 32'h3000);
            check("rr_d1_data_ack", {31'h0, d1_data_ack_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        inst_stb_i = 1'b0; data_stb_i = 1'b0;
        @(negedge clk_i);

        // Single fetch, ram ack sampled three edges after the grant.
        exp_inst(32'h1000, 32'hDEADBEEF);
        inst_addr_i = 32'h1000; inst_stb_i = 1'b1;
        @(negedge clk_i);
        check("fetch_stb_e0", {31'h0, ram_stb_o}, 32'h1);
        repeat (2) begin
            @(negedge clk_i);
            check("fetch_stb_hold", {31'h0, ram_stb_o}, 32'h1);
        end
        ram_ack_i = 1'b1; ram_data_i = 32'hDEADBEEF;
        @(negedge clk_i);
        check("fetch_stb_drop", {31'h0, ram_stb_o}, 32'h0);
        check("fetch_ack", {30'h0, inst_ack_o, data_ack_o}, 32'h2);
        ram_ack_i = 1'b0; inst_stb_i = 1'b0;
        @(negedge clk_i);
        check("fetch_ack_one_cycle", {31'h0, inst_ack_o}, 32'h0);
        check("fetch_data_hold", inst_data_o, 32'hDEADBEEF);

        // Byte store.
        do_data(4'b0001, 1'b1, 32'h2003, TagNone, 32'h55, 2, 32'h0, 1'b0);
        check("store_ack", {30'h0, inst_ack_o, data_ack_o}, 32'h1);
        @(negedge clk_i);
        check("store_ack_one_cycle", {31'h0, data_ack_o}, 32'h0);

        // sc.w failure tag.
        do_data(4'hF, 1'b1, 32'h6000, TagScUnlock, 32'h77, 1, 32'h0, 1'b1);
        check("scw_tag_with_ack", {30'h0, data_ack_o, data_data_tag_o}, 32'h3);
        @(negedge clk_i);
        check("scw_tag_cleared", {30'h0, data_ack_o, data_data_tag_o}, 32'h0);

        // AMO lock holds off fetches until the unlocking write completes.
        exp_grant_q.push_back('{32'h5000, 4'hF, 1'b0, TagAmoLock, 32'h0});
        exp_resp_q.push_back('{1'b0, 32'h1111, 1'b0});
        data_sel_i = 4'hF; data_we_i = 1'b0; data_addr_i = 32'h5000;
        data_addr_tag_i = TagAmoLock; data_data_i = 32'h0; data_stb_i = 1'b1;
        @(negedge clk_i);
        inst_addr_i = 32'h7000; inst_stb_i = 1'b1;
        serve(2, 32'h1111, 1'b0);
        data_stb_i = 1'b0;
        @(negedge clk_i);
        repeat (4) begin
            @(negedge clk_i);
            check("amo_fetch_blocked", {31'h0, ram_stb_o}, 32'h0);
        end
        do_data(4'hF, 1'b1, 32'h5000, TagAmoUnlock, 32'h2222, 2, 32'h0, 1'b0);
        exp_inst(32'h7000, 32'h3333);
        @(negedge clk_i);
        check("unlock_gap", {31'h0, ram_stb_o}, 32'h0);
        @(negedge clk_i);
        check("unlock_fetch_grant", {31'h0, ram_stb_o}, 32'h1);
        check("unlock_fetch_addr", ram_addr_o, 32'h7000);
        serve(1, 32'h3333, 1'b0);
        inst_stb_i = 1'b0;
        @(negedge clk_i);

        // LR read never locks the bus.
        do_data(4'hF, 1'b0, 32'h5100, TagLrLock, 32'h0, 1, 32'h4444, 1'b0);
        @(negedge clk_i);
        exp_inst(32'h7100, 32'h5555);
        inst_addr_i = 32'h7100; inst_stb_i = 1'b1;
        @(negedge clk_i);
        check("lr_no_block", {31'h0, ram_stb_o}, 32'h1);
        serve(1, 32'h5555, 1'b0);
        inst_stb_i = 1'b0;
        @(negedge clk_i);

        // Async reset mid-GRANT while locked: transaction dropped, lock cleared.
        do_data(4'hF, 1'b0, 32'h5200, TagAmoLock, 32'h0, 1, 32'h6666, 1'b0);
        @(negedge clk_i);
        exp_grant_q.push_back('{32'h5300, 4'hF, 1'b1, TagNone, 32'h99});
        data_we_i = 1'b1; data_addr_i = 32'h5300; data_addr_tag_i = TagNone;
        data_data_i = 32'h99; data_stb_i = 1'b1;
        inst_addr_i = 32'h7200; inst_stb_i = 1'b1;
        @(negedge clk_i);
        check("rst_pre_stb", {31'h0, ram_stb_o}, 32'h1);
        #1 rst_i = 1'b1;
        #1 check("rst_async_stb", {31'h0, ram_stb_o}, 32'h0);
        data_stb_i = 1'b0;
        repeat (2) @(negedge clk_i);
        exp_inst(32'h7200, 32'h8888);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_fetch_grant", {31'h0, ram_stb_o}, 32'h1);
        serve(1, 32'h8888, 1'b0);
        inst_stb_i = 1'b0;
        repeat (3) @(negedge clk_i);

        check("grant_queue_drained", exp_grant_q.size(), 32'h0);
        check("resp_queue_drained", exp_resp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
